// File: rtl/rest4b_serial.sv
// rest4b_serial: bit-serial 4-bit subtractor (LSB first) with a registered
// borrow, followed by a two's-complement to sign+magnitude conversion.
// Started by init in IDLE; signals completion with a one-cycle done pulse.
module rest4b_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic [3:0] xi,
  input  logic [3:0] yi,
  output logic [3:0] zi,
  output logic       sign,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] r_q, r_d;
  logic       bw_q, bw_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] zi_q, zi_d;
  logic       sign_q, sign_d;
  logic       done_q, done_d;

  // One full-subtractor slice on the current LSBs of the operand shifters.
  logic diff_bit;
  logic borrow_nxt;

  // Full-subtractor cell for the bit currently at position 0.
  always_comb begin
    diff_bit   = a_q[0] ^ b_q[0] ^ bw_q;
    borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  end

  // Next-state and datapath control for IDLE -> SUB (x4) -> FIX.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    zi_d    = zi_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          // Capture operands; later changes on xi/yi are ignored.
          a_d     = xi;
          b_d     = yi;
          bw_d    = 1'b0;
          r_d     = 4'b0000;
          cnt_d   = 2'd0;
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        bw_d  = borrow_nxt;
        a_d   = {1'b0, a_q[3:1]};
        b_d   = {1'b0, b_q[3:1]};
        r_d   = {diff_bit, r_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = FIX;
        end else begin
          state_d = SUB;
        end
      end
      FIX: begin
        // A final borrow means the raw modulo-16 result is negative.
        if (bw_q) begin
          zi_d   = ~r_q + 4'd1;
          sign_d = 1'b1;
        end else begin
          zi_d   = r_q;
          sign_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins at every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      r_q     <= 4'b0000;
      bw_q    <= 1'b0;
      cnt_q   <= 2'd0;
      zi_q    <= 4'b0000;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      zi_q    <= zi_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
    end
  end

  assign zi   = zi_q;
  assign sign = sign_q;
  assign done = done_q;

endmodule

// File: tb/tb_rest4b_serial.sv
// Directed testbench for rest4b_serial: reset, directed vectors with
// hand-computed results, operand stability, mid-operation reset and an
// exhaustive back-to-back sweep against a reference model.
module tb_rest4b_serial;

  logic       clk;
  logic       rst;
  logic       init;
  logic [3:0] xi;
  logic [3:0] yi;
  logic [3:0] zi;
  logic       sign;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] prev_zi;
  logic       prev_sign;

  rest4b_serial dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .xi   (xi),
    .yi   (yi),
    .zi   (zi),
    .sign (sign),
    .done (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with init pulsed; optionally scramble inputs during SUB.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] ezi, input logic esign,
                        input bit perturb, input string tag);
    xi = x; yi = y; init = 1'b1;
    tick();                       // E0
    init = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (perturb) begin
        xi   = 4'($urandom_range(0, 15));
        yi   = 4'($urandom_range(0, 15));
        init = (c % 2 == 1) ? 1'b1 : 1'b0;
      end
      tick();                     // E1..E4
      check({tag, "_done_sub"}, {7'd0, done}, 8'd0);
      check({tag, "_zi_hold"},  {4'd0, zi},   {4'd0, prev_zi});
      check({tag, "_sg_hold"},  {7'd0, sign}, {7'd0, prev_sign});
    end
    init = 1'b0;
    tick();                       // E5
    check({tag, "_zi"},   {4'd0, zi},   {4'd0, ezi});
    check({tag, "_sign"}, {7'd0, sign}, {7'd0, esign});
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    tick();                       // E6
    check({tag, "_done_clr"}, {7'd0, done}, 8'd0);
    check({tag, "_zi_after"}, {4'd0, zi},   {4'd0, ezi});
    prev_zi   = ezi;
    prev_sign = esign;
  endtask

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] ezi;
    logic       esign;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dh;
    logic [3:0] ex_zi;
    logic       ex_sign;
    int kx, ky;

    vecs[0] = '{4'd9,  4'd4,  4'd5,  1'b0};
    vecs[1] = '{4'd7,  4'd7,  4'd0,  1'b0};
    vecs[2] = '{4'd3,  4'd5,  4'd2,  1'b1};
    vecs[3] = '{4'd0,  4'd15, 4'd15, 1'b1};
    vecs[4] = '{4'd0,  4'd8,  4'd8,  1'b1};
    vecs[5] = '{4'd15, 4'd0,  4'd15, 1'b0};

    // Reset with init held high: nothing may start.
    rst = 1'b1; init = 1'b1; xi = 4'd9; yi = 4'd4;
    tick();
    tick();
    check("rst_zi",   {4'd0, zi},   8'd0);
    check("rst_sign", {7'd0, sign}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    init = 1'b0;
    rst  = 1'b0;
    dh = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done) dh++;
    end
    check("rst_no_op", dh[7:0], 8'd0);
    prev_zi = 4'd0; prev_sign = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].x, vecs[i].y, vecs[i].ezi, vecs[i].esign, 1'b0, $sformatf("vec%0d", i));

    // Stability: inputs and init scrambled during SUB.
    run_op(4'd12, 4'd1, 4'd11, 1'b0, 1'b1, "stab_a");
    run_op(4'd2, 4'd14, 4'd12, 1'b1, 1'b1, "stab_b");
    // Hold afterwards with init low.
    for (int i = 0; i < 3; i++) tick();
    check("hold_zi",   {4'd0, zi},   8'd12);
    check("hold_sign", {7'd0, sign}, 8'd1);

    // Reset at E3 aborts the operation.
    xi = 4'd1; yi = 4'd9; init = 1'b1;
    tick();                       // E0
    init = 1'b0;
    tick();                       // E1
    tick();                       // E2
    rst = 1'b1;
    tick();                       // E3
    rst = 1'b0;
    check("midrst_zi",   {4'd0, zi},   8'd0);
    check("midrst_sign", {7'd0, sign}, 8'd0);
    dh = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dh++;
    end
    check("midrst_no_done", dh[7:0], 8'd0);
    prev_zi = 4'd0; prev_sign = 1'b0;
    run_op(4'd10, 4'd3, 4'd7, 1'b0, 1'b0, "after_rst");

    // Exhaustive back-to-back sweep with init held high.
    xi = 4'd0; yi = 4'd0; init = 1'b1;
    tick();                       // E0 of pair 0
    for (int k = 0; k < 256; k++) begin
      kx = k / 16;
      ky = k % 16;
      ex_sign = (kx < ky);
      ex_zi   = ex_sign ? 4'(ky - kx) : 4'(kx - ky);
      xi = 4'((k + 1) / 16);
      yi = 4'((k + 1) % 16);
      if (k == 255) init = 1'b0;
      dh = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (done) dh++;
      end
      check($sformatf("b2b%0d_early_done", k), dh[7:0], 8'd0);
      tick();                     // E5
      check($sformatf("b2b%0d_done", k), {7'd0, done}, 8'd1);
      check($sformatf("b2b%0d_zi", k),   {4'd0, zi},   {4'd0, ex_zi});
      check($sformatf("b2b%0d_sign", k), {7'd0, sign}, {7'd0, ex_sign});
      tick();                     // next E0
      check($sformatf("b2b%0d_done_clr", k), {7'd0, done}, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
